// File: rtl/mult_pkg.sv
// Shared types and default sizing for the radix-32 multiple-table builder.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MULT_IN_W  = 32;
  localparam int MULT_OUT_W = 64;
  localparam int MULT_NENT  = 32;
  localparam int MULT_IDX_W = 5;

endpackage

// File: rtl/mult_table_regfile.sv
// NENT x OUT_W register bank: one synchronous write port, async clear, all entries packed on one bus.
module mult_table_regfile #(
  parameter int OUT_W = 64,
  parameter int NENT  = 32,
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [OUT_W-1:0]      wdata,
  output logic [NENT*OUT_W-1:0] table_o
);

  logic [OUT_W-1:0] mem_q [NENT];

  // NOTE: this bank is cleared by reset because the mux reads every entry
  // combinationally; an unreset array would expose X to the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NENT; k++) begin : g_rd
    assign table_o[k*OUT_W +: OUT_W] = mem_q[k];
  end

endmodule

// File: rtl/mult_table_builder.sv
// Builds the k*M multiple table (k = 0..NENT-1) by repeated addition, one entry per cycle.
// Optional MTB_STREAM_EN adds a registered write-stream port (wr_en/wr_addr/wr_data).
module mult_table_builder
  import mult_pkg::*;
#(
  parameter int IN_W  = MULT_IN_W,
  parameter int OUT_W = MULT_OUT_W,
  parameter int NENT  = MULT_NENT,
  parameter int IDX_W = MULT_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_i,
  input  logic [IN_W-1:0]       mcand,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [NENT*OUT_W-1:0] table_o
`ifdef MTB_STREAM_EN
  ,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      wr_addr,
  output logic [OUT_W-1:0]      wr_data
`endif
);

  localparam int              EXT_W    = OUT_W - IN_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NENT - 1);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] mext_q, mext_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             we;

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mext_d  = mext_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FILL;
          mext_d  = signed_i ? {{EXT_W{mcand[IN_W-1]}}, mcand} : {{EXT_W{1'b0}}, mcand};
          acc_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      FILL: begin
        // Entry idx receives the running sum idx*M; start is ignored here.
        we    = 1'b1;
        acc_d = acc_q + mext_q;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mext_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mext_q  <= mext_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  mult_table_regfile #(
    .OUT_W (OUT_W),
    .NENT  (NENT),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (idx_q),
    .wdata   (acc_q),
    .table_o (table_o)
  );

  assign busy  = (state_q == FILL);
  assign done  = done_q;
  assign valid = valid_q;

`ifdef MTB_STREAM_EN
  logic             wr_en_q, wr_en_d;
  logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [OUT_W-1:0] wr_data_q, wr_data_d;

  always_comb begin
    wr_en_d   = we;
    wr_addr_d = idx_q;
    wr_data_d = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
`endif

endmodule
